// File: rtl/dcache_2way.sv
// Two-way set-associative write-back data cache with 256-bit lines and LRU replacement.
// Optional hit/miss counters are enabled with DCACHE_STATS_EN.
module dcache_2way #(
  parameter int SET_BITS = 5,
  parameter int ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [255:0]      mem_data_i,
  input  logic              mem_ack_i,
  output logic [255:0]      mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [31:0]       p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [31:0]       p1_data_o,
`ifdef DCACHE_STATS_EN
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o,
`endif
  output logic              p1_stall_o
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = ADDR_W - 5 - SET_BITS;

  typedef enum logic [2:0] {
    IDLE, MISS, WRITEBACK, READMISS, READMISSOK
  } state_e;

  state_e state_q, state_d;
  logic   victim_q, victim_d;
  logic   mem_en_q, mem_en_d;
  logic   mem_wr_q, mem_wr_d;

  logic [1:0]       valid_q [SETS];
  logic [1:0]       dirty_q [SETS];
  logic [SETS-1:0]  lru_q;
  logic [TAG_W-1:0] tag_q  [2][SETS];
  logic [255:0]     data_q [2][SETS];

  logic                req;
  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag;
  logic [2:0]          wsel;
  logic [7:0]          wbase;
  logic [1:0]          way_hit;
  logic                hit;
  logic                hit_way;
  logic                pick;
  logic                refill;
  logic                unused_addr;

  assign req   = p1_MemRead_i | p1_MemWrite_i;
  assign idx   = p1_addr_i[SET_BITS+4:5];
  assign tag   = p1_addr_i[ADDR_W-1:SET_BITS+5];
  assign wsel  = p1_addr_i[4:2];
  assign wbase = {wsel, 5'b0};
  assign unused_addr = ^p1_addr_i[1:0];

  always_comb begin
    for (int w = 0; w < 2; w++) begin
      way_hit[w] = valid_q[idx][w] && (tag_q[w][idx] == tag);
    end
  end

  // Lookups only count while idle so the refilled line is re-read in IDLE.
  assign hit        = req && (state_q == IDLE) && (|way_hit);
  assign hit_way    = way_hit[1];
  assign p1_stall_o = req && !hit;
  assign p1_data_o  = data_q[hit_way][idx][wbase +: 32];

  always_comb begin
    pick = lru_q[idx];
    if (!valid_q[idx][0]) begin
      pick = 1'b0;
    end else if (!valid_q[idx][1]) begin
      pick = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    mem_en_d = mem_en_q;
    mem_wr_d = mem_wr_q;
    refill   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && !hit) begin
          state_d  = MISS;
          victim_d = pick;
        end
      end
      MISS: begin
        mem_en_d = 1'b1;
        if (valid_q[idx][victim_q] && dirty_q[idx][victim_q]) begin
          mem_wr_d = 1'b1;
          state_d  = WRITEBACK;
        end else begin
          mem_wr_d = 1'b0;
          state_d  = READMISS;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          mem_wr_d = 1'b0;
          state_d  = READMISS;
        end
      end
      READMISS: begin
        if (mem_ack_i) begin
          refill   = 1'b1;
          mem_en_d = 1'b0;
          state_d  = READMISSOK;
        end
      end
      READMISSOK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      victim_q <= 1'b0;
      mem_en_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      mem_en_q <= mem_en_d;
      mem_wr_q <= mem_wr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      lru_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= 2'b00;
        dirty_q[s] <= 2'b00;
      end
    end else begin
      if (hit) begin
        lru_q[idx] <= ~hit_way;
        if (p1_MemWrite_i) begin
          dirty_q[idx][hit_way] <= 1'b1;
        end
      end
      if (refill) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
    end
  end

  // Line data and tags are qualified by valid, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (hit && p1_MemWrite_i) begin
      data_q[hit_way][idx][wbase +: 32] <= p1_data_i;
    end
    if (refill) begin
      data_q[victim_q][idx] <= mem_data_i;
      tag_q[victim_q][idx]  <= tag;
    end
  end

  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_wr_q;
  assign mem_data_o   = data_q[victim_q][idx];
  assign mem_addr_o   = {(state_q == WRITEBACK) ? tag_q[victim_q][idx] : tag,
                         idx, 5'b0};

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'b0, hit};
    miss_cnt_d = miss_cnt_q
               + {31'b0, (state_q == IDLE) && req && !hit};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_2way.sv
// Directed bench for dcache_2way: refill, store hit, LRU eviction,
// dirty write-back and reset abort, against a pattern memory.
module tb_dcache_2way;

  logic         clk;
  logic         rst_n;
  logic [255:0] mem_data_i;
  logic         mem_ack;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  p1_wdata;
  logic [31:0]  p1_addr;
  logic         p1_rd;
  logic         p1_wr;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  dcache_2way #(.SET_BITS(5), .ADDR_W(32)) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack),
    .mem_data_o   (mem_data_o),
    .mem_addr_o   (mem_addr_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .p1_data_i    (p1_wdata),
    .p1_addr_i    (p1_addr),
    .p1_MemRead_i (p1_rd),
    .p1_MemWrite_i(p1_wr),
    .p1_data_o    (p1_data_o),
`ifdef DCACHE_STATS_EN
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt),
`endif
    .p1_stall_o   (p1_stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;

  int          nrd = 0;
  int          nwr = 0;
  int          lat = 0;
  logic [31:0]  rd_addr = '0;
  logic [31:0]  wb_addr = '0;
  logic [255:0] wb_data = '0;

  // Word i of the line at A reads back as C0DE_xxxx with xxxx = A[15:0] + 4i.
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) begin
      l[i*32 +: 32] = {16'hC0DE, a[15:0] + 16'(i*4)};
    end
    return l;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ack <= 1'b0;
      lat     <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_ack) begin
        lat <= 0;
        if (mem_write_o) begin
          nwr     <= nwr + 1;
          wb_addr <= mem_addr_o;
          wb_data <= mem_data_o;
        end else begin
          nrd     <= nrd + 1;
          rd_addr <= mem_addr_o;
        end
      end else if (mem_enable_o) begin
        if (lat == 2) begin
          mem_ack    <= 1'b1;
          mem_data_i <= line_of(mem_addr_o);
          lat        <= 0;
        end else begin
          lat <= lat + 1;
        end
      end else begin
        lat <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic wr,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output int stalls);
    stalls   = 0;
    p1_addr  = a;
    p1_wdata = wd;
    p1_wr    = wr;
    p1_rd    = !wr;
    #1;
    while (p1_stall_o && stalls < 200) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    chk("access_timeout", 256'(stalls < 200), 256'(1));
    rd = p1_data_o;
    @(posedge clk);
    #1;
    p1_rd = 1'b0;
    p1_wr = 1'b0;
  endtask

  logic [31:0] rd;
  int          st;
  int          r0, w0;
  int          waited;

  initial begin
    rst_n      = 1'b0;
    p1_addr    = '0;
    p1_wdata   = '0;
    p1_rd      = 1'b0;
    p1_wr      = 1'b0;
    mem_data_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_enable", 256'(mem_enable_o), 256'(0));
    chk("rst_write", 256'(mem_write_o), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_stall", 256'(p1_stall_o), 256'(0));

    access(32'h40, 1'b0, '0, rd, st);
    chk("ld40_missed", 256'(st > 0), 256'(1));
    chk("ld40_reads", 256'(nrd), 256'(1));
    chk("ld40_raddr", 256'(rd_addr), 256'(32'h40));
    chk("ld40_data", 256'(rd), 256'(32'hC0DE0040));

    r0 = nrd; w0 = nwr;
    access(32'h44, 1'b1, 32'hDEADBEEF, rd, st);
    chk("st44_nostall", 256'(st), 256'(0));
    access(32'h44, 1'b0, '0, rd, st);
    chk("ld44_nostall", 256'(st), 256'(0));
    chk("ld44_data", 256'(rd), 256'(32'hDEADBEEF));
    access(32'h48, 1'b0, '0, rd, st);
    chk("ld48_data", 256'(rd), 256'(32'hC0DE0048));
    chk("hits_no_traffic", 256'(nrd + nwr), 256'(r0 + w0));

    access(32'h440, 1'b0, '0, rd, st);
    chk("ld440_missed", 256'(st > 0), 256'(1));
    chk("ld440_data", 256'(rd), 256'(32'hC0DE0440));
    chk("ld440_nowb", 256'(nwr), 256'(0));

    access(32'h840, 1'b0, '0, rd, st);
    chk("ld840_data", 256'(rd), 256'(32'hC0DE0840));
    chk("wb_count", 256'(nwr), 256'(1));
    chk("wb_addr", 256'(wb_addr), 256'(32'h40));
    chk("wb_word1", 256'(wb_data[63:32]), 256'(32'hDEADBEEF));
    chk("wb_word0", 256'(wb_data[31:0]), 256'(32'hC0DE0040));
    chk("ld840_raddr", 256'(rd_addr), 256'(32'h840));

    r0 = nrd;
    access(32'h40, 1'b0, '0, rd, st);
    chk("reld40_missed", 256'(st > 0), 256'(1));
    chk("reld40_reads", 256'(nrd), 256'(r0 + 1));
    chk("reld40_data", 256'(rd), 256'(32'hC0DE0040));
    chk("reld40_clean_evict", 256'(nwr), 256'(1));
    access(32'h84C, 1'b0, '0, rd, st);
    chk("ld84c_hit", 256'(st), 256'(0));
    chk("ld84c_data", 256'(rd), 256'(32'hC0DE084C));
    access(32'h440, 1'b0, '0, rd, st);
    chk("ld440_again_missed", 256'(st > 0), 256'(1));

    access(32'h844, 1'b1, 32'h12345678, rd, st);
    chk("st844_hit", 256'(st), 256'(0));
    access(32'h444, 1'b1, 32'h9ABCDEF0, rd, st);
    chk("st444_hit", 256'(st), 256'(0));

    // Miss on a set whose LRU way is dirty, then reset mid write-back.
    p1_addr = 32'hC40;
    p1_rd   = 1'b1;
    waited  = 0;
    while (!(mem_enable_o && mem_write_o) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk("wb_started", 256'(waited < 50), 256'(1));
    chk("wb_addr_live", 256'(mem_addr_o), 256'(32'h840));
    chk("wb_data_live", 256'(mem_data_o[63:32]), 256'(32'h12345678));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_abort_enable", 256'(mem_enable_o), 256'(0));
    chk("rst_abort_write", 256'(mem_write_o), 256'(0));
    p1_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    access(32'h44, 1'b0, '0, rd, st);
    chk("post_rst_missed", 256'(st > 0), 256'(1));
    chk("post_rst_raddr", 256'(rd_addr), 256'(32'h40));
    chk("post_rst_data", 256'(rd), 256'(32'hC0DE0044));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
